// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_tx among NUM_REQ byte-stream requesters
// Grants are held across multi-byte packets until a last byte or a lock timeout.
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_TO = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 strt_tx,
  output logic [7:0]           tx_data,
  input  logic                 tx_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_TO + 1);
  localparam logic [NUM_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, LOCK} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   g_idx;
  logic [CW-1:0]   lock_cnt;
  logic            tx_done_q;
  logic            last_q;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan;
  logic [PW-1:0]   next_ptr;
  logic            done_rise;

  // Completion is only a fresh rising edge; a stale high level never counts.
  assign done_rise = tx_done & ~tx_done_q;
  assign next_ptr  = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_vld && req[scan]) begin
        pick_vld = 1'b1;
        pick_idx = scan;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ack       <= '0;
      strt_tx   <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      g_idx     <= '0;
      lock_cnt  <= '0;
      tx_done_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      strt_tx   <= 1'b0;
      ack       <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            g_idx   <= pick_idx;
            grant   <= ONE << pick_idx;
            ack     <= ONE << pick_idx;
            tx_data <= req_data[{pick_idx, 3'b000} +: 8];
            last_q  <= req_last[pick_idx];
            strt_tx <= 1'b1;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (done_rise) begin
            if (last_q) begin
              grant  <= '0;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              lock_cnt <= '0;
              state    <= LOCK;
            end
          end
        end
        LOCK: begin
          // A pending owner byte beats an expiring timeout.
          if (req[g_idx]) begin
            tx_data  <= req_data[{g_idx, 3'b000} +: 8];
            last_q   <= req_last[g_idx];
            strt_tx  <= 1'b1;
            ack      <= grant;
            lock_cnt <= '0;
            state    <= START;
          end else if (lock_cnt == CW'(LOCK_TO - 1)) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb with requester agents and a uart_tx model
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int LT = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic           strt_tx;
  logic [7:0]     tx_data;
  logic           tx_done = 1'b1;

  uart_tx_arb #(.NUM_REQ(N), .LOCK_TO(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .busy(busy), .strt_tx(strt_tx), .tx_data(tx_data),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] aq [N][$];
  int         exp_idx [$];
  logic [7:0] exp_data [$];
  int         model_ptr = 0;
  int         bit_cycles = 5;
  int         stale_hold = 0;
  bit         uart_active = 0;
  logic [7:0] cur_tx = 8'h00;
  bit         have_cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int r, input logic [8:0] b);
    aq[r].push_back(b);
  endtask

  // Reference: serve the first non-empty requester from the pointer, send its whole
  // packet (ends at a last byte or when the requester runs dry), then rotate past it.
  task automatic predict();
    logic [8:0] m [N][$];
    logic [8:0] b;
    int g;
    bit any;
    foreach (aq[i]) m[i] = aq[i];
    forever begin
      any = 0;
      for (int i = 0; i < N; i++) if (m[i].size() > 0) any = 1;
      if (!any) break;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && m[(model_ptr + k) % N].size() > 0) g = (model_ptr + k) % N;
      do begin
        b = m[g].pop_front();
        exp_idx.push_back(g);
        exp_data.push_back(b[7:0]);
      end while (!b[8] && m[g].size() > 0);
      model_ptr = (g + 1) % N;
    end
  endtask

  function automatic bit agents_empty();
    for (int i = 0; i < N; i++) if (aq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input int max);
    int n = 0;
    while (n < max && !(agents_empty() && !busy && !uart_active && exp_idx.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(n < max), 32'(1));
  endtask

  task automatic wait_strt(input int max);
    int n = 0;
    while (!strt_tx && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("strt_seen", 32'(strt_tx), 32'(1));
  endtask

  task automatic wait_done_high(input int max);
    int n = 0;
    while (!tx_done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(tx_done), 32'(1));
  endtask

  // Requester agents: hold the head byte until it is acked.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst_n && ack[i] && aq[i].size() > 0) void'(aq[i].pop_front());
      req[i]            = (aq[i].size() > 0);
      req_data[8*i +: 8] = (aq[i].size() > 0) ? aq[i][0][7:0] : 8'h00;
      req_last[i]       = (aq[i].size() > 0) ? aq[i][0][8] : 1'b0;
    end
  end

  // uart_tx model: done level drops on start (optionally late) and rises at end of frame.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && strt_tx) begin
      uart_active = 1;
      repeat (stale_hold) @(posedge clk);
      #1 tx_done = 1'b0;
      repeat (bit_cycles) @(posedge clk);
      #1 tx_done = 1'b1;
      uart_active = 0;
    end
  end

  // Monitor: each start is compared against the scoreboard head.
  initial forever begin
    int e;
    logic [7:0] d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      have_cur = 0;
    end else begin
      chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
      if (strt_tx) begin
        if (exp_idx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got tx_data %0h grant %0h, expected no start", tx_data, grant);
        end else begin
          e = exp_idx.pop_front();
          d = exp_data.pop_front();
          chk("start_ack", 32'(ack), 32'(1) << e);
          chk("start_grant", 32'(grant), 32'(1) << e);
          chk("start_data", 32'(tx_data), 32'(d));
        end
        cur_tx   = tx_data;
        have_cur = 1;
      end else begin
        chk("no_stray_ack", 32'(ack), 32'(0));
        if (grant != '0 && have_cur) chk("tx_data_hold", 32'(tx_data), 32'(cur_tx));
      end
    end
  end

  initial begin
    int np, len;
    logic [8:0] b;

    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_strt", 32'(strt_tx), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    rst_n = 1'b1;
    model_ptr = 0;

    // Single last byte from requester 1 with a full-length frame.
    bit_cycles = 2604 * 10;
    load(1, {1'b1, 8'hA5});
    predict();
    @(negedge clk);
    chk("t1_strt_early", 32'(strt_tx), 32'(0));
    @(negedge clk);
    chk("t1_strt", 32'(strt_tx), 32'(1));
    chk("t1_ack", 32'(ack), 32'(4'b0010));
    chk("t1_data", 32'(tx_data), 32'(8'hA5));
    wait_done_high(30000);
    @(negedge clk);
    chk("t1_release_grant", 32'(grant), 32'(0));
    chk("t1_release_busy", 32'(busy), 32'(0));

    // Three-byte packet from requester 2 while requester 0 waits.
    bit_cycles = 8;
    load(2, {1'b0, 8'h11});
    load(2, {1'b0, 8'h22});
    load(2, {1'b1, 8'h33});
    load(0, {1'b1, 8'h5A});
    predict();
    wait_idle(2000);

    // Requester 1 abandons a packet; lock times out.
    load(1, {1'b0, 8'h77});
    predict();
    wait_strt(100);
    wait_done_high(200);
    repeat (LT) @(negedge clk);
    chk("t4_lock_grant", 32'(grant), 32'(4'b0010));
    chk("t4_lock_busy", 32'(busy), 32'(1));
    @(negedge clk);
    chk("t4_timeout_grant", 32'(grant), 32'(0));
    chk("t4_timeout_busy", 32'(busy), 32'(0));
    load(0, {1'b1, 8'h0F});
    load(3, {1'b1, 8'hF3});
    predict();
    wait_idle(2000);

    // All four requesting from reset: strict rotation.
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) load(i, {1'b1, 8'(8'h40 + 8 * r + i)});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    predict();
    wait_idle(2000);

    // Stale done level at start must not complete the byte.
    stale_hold = 12;
    load(2, {1'b1, 8'hC3});
    predict();
    wait_strt(100);
    repeat (10) @(negedge clk);
    chk("t5_stale_grant", 32'(grant), 32'(4'b0100));
    chk("t5_stale_busy", 32'(busy), 32'(1));
    wait_idle(2000);
    stale_hold = 0;

    // Randomized packet mixes.
    for (int rnd = 0; rnd < 15; rnd++) begin
      bit_cycles = $urandom_range(2, 20);
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            b[7:0] = 8'($urandom);
            b[8]   = (k == len - 1);
            if (k == len - 1 && p == np - 1 && $urandom_range(0, 4) == 0) b[8] = 1'b0;
            load(i, b);
          end
        end
      end
      predict();
      wait_idle(20000);
    end

    // Reset during WAIT abandons the frame; pointer restarts at 0.
    load(3, {1'b1, 8'hE7});
    predict();
    wait_strt(100);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_strt", 32'(strt_tx), 32'(0));
    chk("t6_ack", 32'(ack), 32'(0));
    chk("t6_grant", 32'(grant), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_tx_data", 32'(tx_data), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int n = 0;
      while (uart_active && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("t6_uart_quiet", 32'(uart_active), 32'(0));
    end
    model_ptr = 0;
    load(3, {1'b1, 8'h33});
    load(1, {1'b1, 8'h11});
    predict();
    wait_idle(2000);

    chk("scoreboard_empty", 32'(exp_idx.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
